// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_pkg
// Shared types for the 6502 fetch/decode/execute sequencer: the state
// encoding (also shown on the LED display), the supported opcode values and
// a helper for the end-of-instruction branch.
// -----------------------------------------------------------------------------
package cpu_sequencer_pkg;

  // State codes are visible on the LED display, so the values are fixed.
  typedef enum logic [3:0] {
    ST_RESET  = 4'h0,
    ST_WAIT   = 4'h1,
    ST_FETCH  = 4'h2,
    ST_DECODE = 4'h3,
    ST_OPLO_A = 4'h4,
    ST_OPLO_D = 4'h5,
    ST_OPHI_A = 4'h6,
    ST_OPHI_D = 4'h7,
    ST_EXEC   = 4'h8,
    ST_LOAD_D = 4'h9,
    ST_HALT   = 4'hF
  } seq_state_t;

  localparam logic [7:0] OPC_LDA_IMM = 8'hA9;
  localparam logic [7:0] OPC_LDA_ABS = 8'hAD;
  localparam logic [7:0] OPC_STA_ABS = 8'h8D;
  localparam logic [7:0] OPC_JMP_ABS = 8'h4C;
  localparam logic [7:0] OPC_NOP     = 8'hEA;
  localparam logic [7:0] OPC_BRK     = 8'h00;

  // Where an instruction goes once it completes: free run fetches the next
  // opcode immediately, single-step parks in WAIT.
  function automatic seq_state_t end_next(input logic run);
    if (run) begin
      return ST_FETCH;
    end else begin
      return ST_WAIT;
    end
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_if
// Bundles the sequencer's control inputs (run, step, mem_rdata) and its
// datapath strobes/registers toward pcounter, memmux, cpumemory and ledctrl.
//   master : the sequencer (drives strobes, reads run/step/mem_rdata)
//   slave  : the datapath / environment side
// -----------------------------------------------------------------------------
interface cpu_sequencer_if;

  logic        run;
  logic        step;
  logic [7:0]  mem_rdata;
  logic [3:0]  state;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        mm;
  logic        mw;
  logic [7:0]  wdata;
  logic        il;
  logic [7:0]  acc;
  logic [7:0]  opcode;
  logic [15:0] ea;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, step, mem_rdata,
    output state, pc_inc, pc_load, pc_load_val, mm, mw, wdata, il,
           acc, opcode, ea, halted, illegal
  );

  modport slave (
    output run, step, mem_rdata,
    input  state, pc_inc, pc_load, pc_load_val, mm, mw, wdata, il,
           acc, opcode, ea, halted, illegal
  );

endinterface

// File: rtl/cpu_sequencer_step_edge.sv
// -----------------------------------------------------------------------------
// step_edge
// Synchronises the asynchronous step button level with two flops and emits a
// one-cycle registered pulse on each rising edge.
//   i_clk   : system clock
//   i_rst   : synchronous, active-high reset
//   i_step  : raw button level
//   o_pulse : one-cycle pulse, registered, per rising edge of i_step
// -----------------------------------------------------------------------------
module step_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_step,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  // Synchroniser chain, delayed copy and registered rising-edge detect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_step;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle fetch/decode/execute controller for the 6502 datapath. Holds the
// accumulator, opcode and effective-address registers and decodes the
// registered state into the pcounter/memmux/cpumemory strobes.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : cpu_sequencer_if.master (run/step/mem_rdata in; state, strobes,
//          pc_load_val, wdata, acc, opcode, ea, halted, illegal out)
// Memory has one cycle of read latency: *_A states present an address and the
// following *_D state consumes the returned byte.
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  cpu_sequencer_if.master   bus
);

  seq_state_t  r_state;
  seq_state_t  w_next;
  logic [7:0]  r_acc;
  logic [7:0]  r_opcode;
  logic [15:0] r_ea;
  logic        r_illegal;

  logic        w_step_pulse;
  logic        w_pc_inc;
  logic        w_pc_load;
  logic        w_mm;
  logic        w_mw;
  logic        w_il;
  logic        w_acc_ld;
  logic        w_ea_lo_ld;
  logic        w_ea_hi_ld;
  logic        w_set_illegal;

  step_edge u_step_edge (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_step  (bus.step),
    .o_pulse (w_step_pulse)
  );

  // State register plus the accumulator, opcode, address and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_acc     <= 8'h00;
      r_opcode  <= 8'h00;
      r_ea      <= 16'h0000;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_il)          r_opcode   <= bus.mem_rdata;
      if (w_acc_ld)      r_acc      <= bus.mem_rdata;
      if (w_ea_lo_ld)    r_ea[7:0]  <= bus.mem_rdata;
      if (w_ea_hi_ld)    r_ea[15:8] <= bus.mem_rdata;
      if (w_set_illegal) r_illegal  <= 1'b1;
    end
  end

  // Next-state and strobe decode; strobes depend on the registered state
  // (DECODE additionally inspects the arriving opcode byte).
  always_comb begin
    w_next        = r_state;
    w_pc_inc      = 1'b0;
    w_pc_load     = 1'b0;
    w_mm          = 1'b0;
    w_mw          = 1'b0;
    w_il          = 1'b0;
    w_acc_ld      = 1'b0;
    w_ea_lo_ld    = 1'b0;
    w_ea_hi_ld    = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_pc_load = 1'b1;
        w_next    = end_next(bus.run);
      end
      ST_WAIT: begin
        if (w_step_pulse) begin
          w_next = ST_FETCH;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_FETCH: begin
        w_next = ST_DECODE;
      end
      ST_DECODE: begin
        w_il = 1'b1;
        case (bus.mem_rdata)
          OPC_NOP: begin
            w_pc_inc = 1'b1;
            w_next   = end_next(bus.run);
          end
          OPC_BRK: begin
            // PC stays on the BRK byte.
            w_next = ST_HALT;
          end
          OPC_LDA_IMM, OPC_LDA_ABS, OPC_STA_ABS, OPC_JMP_ABS: begin
            w_pc_inc = 1'b1;
            w_next   = ST_OPLO_A;
          end
          default: begin
            w_set_illegal = 1'b1;
            w_next        = ST_HALT;
          end
        endcase
      end
      ST_OPLO_A: begin
        w_next = ST_OPLO_D;
      end
      ST_OPLO_D: begin
        w_pc_inc = 1'b1;
        if (r_opcode == OPC_LDA_IMM) begin
          w_acc_ld = 1'b1;
          w_next   = end_next(bus.run);
        end else begin
          w_ea_lo_ld = 1'b1;
          w_next     = ST_OPHI_A;
        end
      end
      ST_OPHI_A: begin
        w_next = ST_OPHI_D;
      end
      ST_OPHI_D: begin
        w_ea_hi_ld = 1'b1;
        w_pc_inc   = 1'b1;
        w_next     = ST_EXEC;
      end
      ST_EXEC: begin
        // ea drives the memory address for every absolute-mode execute.
        w_mm = 1'b1;
        case (r_opcode)
          OPC_STA_ABS: begin
            w_mw   = 1'b1;
            w_next = end_next(bus.run);
          end
          OPC_JMP_ABS: begin
            w_pc_load = 1'b1;
            w_next    = end_next(bus.run);
          end
          OPC_LDA_ABS: begin
            w_next = ST_LOAD_D;
          end
          default: begin
            w_next = ST_HALT;
          end
        endcase
      end
      ST_LOAD_D: begin
        w_acc_ld = 1'b1;
        w_next   = end_next(bus.run);
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        // Unencoded state: park safely with every strobe low.
        w_next = ST_HALT;
      end
    endcase
  end

  assign bus.state       = r_state;
  assign bus.pc_inc      = w_pc_inc;
  assign bus.pc_load     = w_pc_load;
  assign bus.pc_load_val = (r_state == ST_RESET) ? RESET_VECTOR : r_ea;
  assign bus.mm          = w_mm;
  assign bus.mw          = w_mw;
  assign bus.wdata       = r_acc;
  assign bus.il          = w_il;
  assign bus.acc         = r_acc;
  assign bus.opcode      = r_opcode;
  assign bus.ea          = r_ea;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.illegal     = r_illegal;

endmodule
